load_queue_mp: RTL
==================

# load_queue_mp

Second-generation out-of-order load queue: a circular buffer of in-flight loads keyed by ROB tag, now with `AGU_PORTS` parallel address-writeback ports, an oldest-first fire arbiter to the memory interface, store-dependency masks, replay-kill, in-order commit and branch-flush recovery. Sits between dispatch (allocation), the AGUs (addresses), the data cache (fire/complete) and the ROB (commit/flush). Store-address disambiguation stays outside; this block only holds the masks and honours kills.

## Interface
- `XLEN`, 32, address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `LDQ_SIZE`, 16, entries; power of two, ≥2
- `STQ_SIZE`, 16, store queue entries (mask width)
- `AGU_PORTS`, 2, address writeback ports, ≥1

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-low
- `alloc_ldq_entry` in 1: allocate at tail
- `rob_tag_in` in `ROB_TAG_WIDTH`: tag of the allocated load
- `store_mask_in` in `STQ_SIZE`: older in-flight stores at allocation
- `ldq_full` out 1, `ldq_empty` out 1: occupancy flags
- `agu_address_valid` in `[AGU_PORTS]`: per-port address strobe
- `agu_address_data` in `[AGU_PORTS][XLEN]`: per-port address
- `agu_address_rob_tag` in `[AGU_PORTS][ROB_TAG_WIDTH]`: per-port target tag
- `fire_valid` out 1, `fire_ready` in 1: load issue handshake
- `fire_address` out `XLEN`, `fire_rob_tag` out `ROB_TAG_WIDTH`, `fire_index` out `$clog2(LDQ_SIZE)`: issued load
- `load_completed` in 1, `load_completed_rob_tag` in `ROB_TAG_WIDTH`: cache completion
- `load_kill` in 1, `load_kill_rob_tag` in `ROB_TAG_WIDTH`: replay request from disambiguation
- `store_retired` in 1, `store_retired_index` in `$clog2(STQ_SIZE)`: clears that bit in every mask
- `commit` in 1: ROB retires the head load
- `flush` in 1, `flush_tail_index` in `$clog2(LDQ_SIZE)`: squash from index to tail
- `load_queue_entries` out `[0:LDQ_SIZE-1]` of `load_queue_entry`: full state view

## Operation
- Entry fields: `valid`, `rob_tag`, `address`, `address_valid`, `fired`, `completed`, `store_mask`.
- State: `head`, `tail` (`$clog2(LDQ_SIZE)` bits, wrap naturally), `count` (`$clog2(LDQ_SIZE)+1` bits). `ldq_full = count==LDQ_SIZE`, `ldq_empty = count==0`, both from registered state.
- Alloc: if `alloc_ldq_entry && !ldq_full`, write tail entry: valid=1, tag, mask, all other flags 0; tail+1. Alloc while full is dropped silently.
- AGU: each port compares its tag against every valid entry; on match write `address`, set `address_valid`. Two ports hitting one entry same cycle: lowest port index wins.
- Fire: candidate = valid && address_valid && !fired && !completed. Priority search starts at head, wraps; oldest wins. `fire_valid` = any candidate; outputs describe it. On `fire_valid && fire_ready`, set `fired`.
- Complete: matching valid entry sets `completed`.
- Kill: matching valid entry clears `fired` and `completed` (re-fire later). Kill and complete same entry same cycle: kill wins.
- Store retire: clear bit `store_retired_index` in all masks.
- Commit: head entry valid=0, head+1, count-1. Commit on empty queue is ignored.
- Flush: invalidate entries from `flush_tail_index` up to tail (exclusive, wrapping), `tail <= flush_tail_index`, count recomputed as `flush_tail_index - head` (after commit adjustment). Flush beats same-cycle alloc (alloc dropped); commit still applies. `flush_tail_index == tail` is a no-op.
- Updates never apply to invalid entries; flushed/committed entries ignore same-cycle AGU/complete/kill.

## Timing
- Reset: head=tail=count=0, every entry all-zero, `ldq_empty`=1, `ldq_full`=0, `fire_valid`=0. Reset mid-operation discards all entries next edge.
- Alloc, AGU write, complete, kill, commit, flush: visible one cycle after the edge.
- AGU address captured at edge N → fire outputs valid during cycle N+1 (combinational from registered state).
- `fire_*` stable until accepted only if no higher-priority (older) candidate appears; consumer must not assume stickiness.
- Same-cycle alloc+commit when full: alloc dropped (flag is pre-edge).

## Structure
- Package `ldq_pkg`: `load_queue_entry` typedef and parameter-dependent index widths.
- Sub-module `ldq_oldest_picker`: rotating priority encoder (request vector, head) → grant valid + index; reused by future store queue.

## Test plan
- Reset, alloc 16 tags 0x10..0x1F → `ldq_full`=1; 17th alloc dropped; tail wraps to 0.
- AGU port0 tag 0x12 addr 0x1000, port1 tag 0x11 addr 0x2000 same cycle → next cycle fire shows tag 0x11, addr 0x2000; after accept, tag 0x12.
- Both ports target tag 0x13 (0xA0/0xB0) → address 0xA0.
- Fired tag 0x11: kill+complete same cycle → fired=0, completed=0, re-fires next cycle.
- Head=14, tail=4, flush index 1 → entries 1..3 invalid, tail=1, count=3; same-cycle alloc dropped.
- Mask 0b0101, retire index 2 → 0b0001; commit on empty ignored, count stays 0.

Source files
------------

// File: rtl/ldq_pkg.sv
// Shared types and widths for the multi-port load queue.
//
// load_queue_entry_t is the per-entry state record. Its field widths are fixed
// here and must match the parameters the top is instantiated with. The top's
// parameter defaults come from this package, so the defaults always agree.
package ldq_pkg;

    localparam int unsigned LdqXlen         = 32;
    localparam int unsigned LdqRobTagWidth  = 32;
    localparam int unsigned LdqSize         = 16;
    localparam int unsigned LdqStqSize      = 16;
    localparam int unsigned LdqAguPorts     = 2;
    localparam int unsigned LdqIdxWidth     = $clog2(LdqSize);
    localparam int unsigned LdqCntWidth     = LdqIdxWidth + 1;
    localparam int unsigned StqIdxWidth     = $clog2(LdqStqSize);

    typedef struct packed {
        logic                      valid;
        logic [LdqRobTagWidth-1:0] rob_tag;
        logic [LdqXlen-1:0]        address;
        logic                      address_valid;
        logic                      fired;
        logic                      completed;
        logic [LdqStqSize-1:0]     store_mask;
    } load_queue_entry_t;

endpackage

// File: rtl/ldq_oldest_picker.sv
// Rotating priority encoder: picks the first set request at or after head_i,
// wrapping around, so that the oldest entry of a circular queue wins.
//
// Ports:
//   req_i         request vector, one bit per queue slot
//   head_i        slot index treated as highest priority
//   grant_valid_o at least one request is set
//   grant_idx_o   index of the winning slot (0 when grant_valid_o is low)
//
// NumReq must be a power of two so the index wraps by plain overflow.
module ldq_oldest_picker #(
    parameter int unsigned NumReq = 16
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] head_i,
    output logic                      grant_valid_o,
    output logic [$clog2(NumReq)-1:0] grant_idx_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] idx;

    // Scan from the youngest offset down to the head so the last hit recorded
    // is the one closest to head.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = head_i + IdxW'(i);
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/load_queue_mp.sv
// Out-of-order load queue with multiple AGU writeback ports.
//
// Circular buffer of in-flight loads keyed by ROB tag. Entries are allocated at
// the tail, receive addresses from AGU_PORTS writeback ports, are fired to the
// data cache oldest-first, marked completed by the cache, possibly killed for
// replay, and retired in order from the head. A flush truncates the tail.
//
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   alloc_ldq_entry_i           allocate at tail with rob_tag_i / store_mask_i
//   ldq_full_o, ldq_empty_o     occupancy flags from registered count
//   agu_address_*_i             per-port address writeback (flattened, port 0 in low bits)
//   fire_*                      issue handshake for the oldest ready load
//   load_completed_*_i          cache completion by ROB tag
//   load_kill_*_i               replay request by ROB tag
//   store_retired_*_i           clears one store-mask bit in every entry
//   commit_i                    retire the head entry
//   flush_i, flush_tail_index_i squash entries from the index up to the tail
//   load_queue_entries_o        full registered state view
module load_queue_mp
    import ldq_pkg::*;
#(
    parameter int unsigned XLEN          = LdqXlen,
    parameter int unsigned ROB_TAG_WIDTH = LdqRobTagWidth,
    parameter int unsigned LDQ_SIZE      = LdqSize,
    parameter int unsigned STQ_SIZE      = LdqStqSize,
    parameter int unsigned AGU_PORTS     = LdqAguPorts
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          alloc_ldq_entry_i,
    input  logic [ROB_TAG_WIDTH-1:0]      rob_tag_i,
    input  logic [STQ_SIZE-1:0]           store_mask_i,
    output logic                          ldq_full_o,
    output logic                          ldq_empty_o,

    input  logic [AGU_PORTS-1:0]          agu_address_valid_i,
    input  logic [AGU_PORTS*XLEN-1:0]     agu_address_data_i,
    input  logic [AGU_PORTS*ROB_TAG_WIDTH-1:0] agu_address_rob_tag_i,

    output logic                          fire_valid_o,
    input  logic                          fire_ready_i,
    output logic [XLEN-1:0]               fire_address_o,
    output logic [ROB_TAG_WIDTH-1:0]      fire_rob_tag_o,
    output logic [$clog2(LDQ_SIZE)-1:0]   fire_index_o,

    input  logic                          load_completed_i,
    input  logic [ROB_TAG_WIDTH-1:0]      load_completed_rob_tag_i,
    input  logic                          load_kill_i,
    input  logic [ROB_TAG_WIDTH-1:0]      load_kill_rob_tag_i,

    input  logic                          store_retired_i,
    input  logic [$clog2(STQ_SIZE)-1:0]   store_retired_index_i,

    input  logic                          commit_i,
    input  logic                          flush_i,
    input  logic [$clog2(LDQ_SIZE)-1:0]   flush_tail_index_i,

    output load_queue_entry_t             load_queue_entries_o [LDQ_SIZE]
);

    localparam int unsigned IdxW = $clog2(LDQ_SIZE);
    localparam int unsigned CntW = IdxW + 1;

    load_queue_entry_t entries_q [LDQ_SIZE];
    load_queue_entry_t entries_d [LDQ_SIZE];
    logic [IdxW-1:0]   head_q, head_d;
    logic [IdxW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              full, empty;
    logic              alloc_en, commit_en, flush_en, fire_accept;
    logic [LDQ_SIZE-1:0] fire_req;
    logic              grant_valid;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   flush_off, flush_span, flush_cnt;

    assign full  = (count_q == CntW'(LDQ_SIZE));
    assign empty = (count_q == '0);

    assign ldq_full_o  = full;
    assign ldq_empty_o = empty;

    // ---------------------------------------------------------------------
    // Fire arbitration (combinational from registered state)
    // ---------------------------------------------------------------------
    always_comb begin
        fire_req = '0;
        for (int i = 0; i < int'(LDQ_SIZE); i++) begin
            fire_req[i] = entries_q[i].valid && entries_q[i].address_valid &&
                          !entries_q[i].fired && !entries_q[i].completed;
        end
    end

    ldq_oldest_picker #(
        .NumReq (LDQ_SIZE)
    ) u_fire_picker (
        .req_i         (fire_req),
        .head_i        (head_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign fire_valid_o   = grant_valid;
    assign fire_address_o = entries_q[grant_idx].address;
    assign fire_rob_tag_o = entries_q[grant_idx].rob_tag;
    assign fire_index_o   = grant_idx;
    assign fire_accept    = grant_valid && fire_ready_i;

    // ---------------------------------------------------------------------
    // Control decisions
    // ---------------------------------------------------------------------
    assign commit_en = commit_i && !empty;
    // A flush to the current tail squashes nothing and is treated as absent.
    assign flush_en  = flush_i && (flush_tail_index_i != tail_q);
    assign alloc_en  = alloc_ldq_entry_i && !full && !flush_en;

    // ---------------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------------
    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q + IdxW'(commit_en);
        tail_d     = tail_q + IdxW'(alloc_en);
        count_d    = count_q + CntW'(alloc_en) - CntW'(commit_en);
        flush_off  = '0;
        flush_span = '0;
        flush_cnt  = '0;

        for (int i = 0; i < int'(LDQ_SIZE); i++) begin
            if (entries_q[i].valid) begin
                if (store_retired_i) begin
                    entries_d[i].store_mask[store_retired_index_i] = 1'b0;
                end
                // Highest port first so port 0 is written last and wins.
                for (int p = int'(AGU_PORTS) - 1; p >= 0; p--) begin
                    if (agu_address_valid_i[p] &&
                        entries_q[i].rob_tag ==
                            agu_address_rob_tag_i[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]) begin
                        entries_d[i].address       = agu_address_data_i[p*XLEN +: XLEN];
                        entries_d[i].address_valid = 1'b1;
                    end
                end
                if (fire_accept && grant_idx == IdxW'(i)) begin
                    entries_d[i].fired = 1'b1;
                end
                if (load_completed_i && entries_q[i].rob_tag == load_completed_rob_tag_i) begin
                    entries_d[i].completed = 1'b1;
                end
                // Kill is applied last so it overrides a same-cycle completion.
                if (load_kill_i && entries_q[i].rob_tag == load_kill_rob_tag_i) begin
                    entries_d[i].fired     = 1'b0;
                    entries_d[i].completed = 1'b0;
                end
            end
        end

        if (commit_en) begin
            entries_d[head_q].valid = 1'b0;
        end

        if (flush_en) begin
            flush_span = tail_q - flush_tail_index_i;
            for (int i = 0; i < int'(LDQ_SIZE); i++) begin
                flush_off = IdxW'(i) - flush_tail_index_i;
                if (flush_off < flush_span) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            tail_d    = flush_tail_index_i;
            flush_cnt = flush_tail_index_i - head_d;
            count_d   = {1'b0, flush_cnt};
        end

        if (alloc_en) begin
            entries_d[tail_q]            = '0;
            entries_d[tail_q].valid      = 1'b1;
            entries_d[tail_q].rob_tag    = rob_tag_i;
            entries_d[tail_q].store_mask = store_mask_i;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(LDQ_SIZE); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < int'(LDQ_SIZE); i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(LDQ_SIZE); i++) begin
            load_queue_entries_o[i] = entries_q[i];
        end
    end

endmodule
